// File: rtl/dff_load_sequencer.sv
// Paced load source: FIFO-buffers upstream words and replays them as single-cycle ce_out/d_out loads.
// Optional macro DFF_SEED_RESET_EN makes d_out reset to SEED instead of zero.
module dff_load_sequencer #(
  parameter int              WIDTH = 4,
  parameter int              DEPTH = 4,
  parameter int              PACE  = 3,
  parameter logic [WIDTH-1:0] SEED = 4'b1001
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       ce_out,
  output logic [WIDTH-1:0]           d_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (PACE > 1) ? $clog2(PACE) : 1;
  localparam logic [PW-1:0] PACE_RELOAD = PW'(PACE - 1);
  localparam logic [CW-1:0] COUNT_FULL  = CW'(DEPTH);
`ifdef DFF_SEED_RESET_EN
  localparam logic [WIDTH-1:0] D_RST = SEED;
`else
  localparam logic [WIDTH-1:0] D_RST = {WIDTH{1'b0}};
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    pacer_q, pacer_d;
  state_e           state_q, state_d;
  logic             ce_q, ce_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             full_q, full_d;
  logic             busy_q, busy_d;
  logic             push_s, pop_s;

  // Pointer, occupancy and FSM next-state; a pop fires whenever the pacer has expired and data waits.
  always_comb begin
    push_s   = in_valid && !full_q;
    pop_s    = (pacer_q == {PW{1'b0}}) && (count_q != {CW{1'b0}});
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1'b1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1'b1)) : rd_ptr_q;
    count_d  = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
    state_d  = IDLE;
    pacer_d  = {PW{1'b0}};
    ce_d     = 1'b0;
    d_d      = d_q;
    case (state_q)
      IDLE: begin
        if (pop_s) begin
          state_d = ISSUE;
          pacer_d = PACE_RELOAD;
          ce_d    = 1'b1;
          d_d     = mem_q[rd_ptr_q];
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE, HOLD: begin
        if (pop_s) begin
          state_d = ISSUE;
          pacer_d = PACE_RELOAD;
          ce_d    = 1'b1;
          d_d     = mem_q[rd_ptr_q];
        end else if (pacer_q != {PW{1'b0}}) begin
          state_d = HOLD;
          pacer_d = pacer_q - PW'(1'b1);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Full is judged on the registered count, so a same-cycle pop never admits a push into a full FIFO.
    full_d = (count_d == COUNT_FULL);
    busy_d = (count_d != {CW{1'b0}}) || (state_d != IDLE);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      pacer_q  <= {PW{1'b0}};
      state_q  <= IDLE;
      ce_q     <= 1'b0;
      d_q      <= D_RST;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pacer_q  <= pacer_d;
      state_q  <= state_d;
      ce_q     <= ce_d;
      d_q      <= d_d;
      full_q   <= full_d;
      busy_q   <= busy_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready = ~full_q;
  assign ce_out   = ce_q;
  assign d_out    = d_q;
  assign count    = count_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dff_load_sequencer.sv
// Bench: two sequencers (PACE=3 and PACE=1) checked against a timestamp/queue reference model.
module tb_dff_load_sequencer;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;
`ifdef DFF_SEED_RESET_EN
  localparam logic [W-1:0] D_RST = 4'b1001;
`else
  localparam logic [W-1:0] D_RST = 4'b0000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0]          in_valid_s = 2'b00;
  logic [W-1:0]        in_data_s  = 4'h0;
  logic [1:0]          in_ready_s, ce_s, busy_s;
  logic [1:0][W-1:0]   d_s;
  logic [1:0][CW-1:0]  count_s;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [W-1:0] mq [2][$];
  int           last_iss [2];
  int           pace [2];
  logic [W-1:0] exp_d [2];
  logic         exp_ce [2];
  int           cyc = 0;
  logic         f_watch = 1'b0;
  int           f_hits = 0;

  always #5 clk = ~clk;

  dff_load_sequencer #(.WIDTH(W), .DEPTH(D), .PACE(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .in_data(in_data_s), .ce_out(ce_s[0]), .d_out(d_s[0]), .count(count_s[0]), .busy(busy_s[0])
  );

  dff_load_sequencer #(.WIDTH(W), .DEPTH(D), .PACE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .in_data(in_data_s), .ce_out(ce_s[1]), .d_out(d_s[1]), .count(count_s[1]), .busy(busy_s[1])
  );

  task automatic chk(input string tag, input int idx, input int act, input int exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d] observed=%0d expected=%0d", tag, idx, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      last_iss[i] = -1000;
      exp_d[i]    = D_RST;
      exp_ce[i]   = 1'b0;
    end
  endtask

  // One clock edge of the reference: issue when PACE edges have elapsed since the last issue
  // and a word was already queued; accept a push only if the queue was not full before the edge.
  task automatic model_edge(input logic [1:0] v, input logic [W-1:0] dat);
    for (int i = 0; i < 2; i++) begin
      bit iss;
      bit psh;
      iss = (mq[i].size() != 0) && ((cyc - last_iss[i]) >= pace[i]);
      psh = v[i] && (mq[i].size() < D);
      if (iss) begin
        exp_d[i]    = mq[i].pop_front();
        last_iss[i] = cyc;
        exp_ce[i]   = 1'b1;
      end else begin
        exp_ce[i]   = 1'b0;
      end
      if (psh) mq[i].push_back(dat);
    end
    cyc++;
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int eb;
      eb = ((mq[i].size() != 0) || (((cyc - 1) - last_iss[i]) < pace[i])) ? 1 : 0;
      chk("ce_out",   i, int'(ce_s[i]),       int'(exp_ce[i]));
      chk("d_out",    i, int'(d_s[i]),        int'(exp_d[i]));
      chk("count",    i, int'(count_s[i]),    mq[i].size());
      chk("in_ready", i, int'(in_ready_s[i]), (mq[i].size() < D) ? 1 : 0);
      chk("busy",     i, int'(busy_s[i]),     eb);
      if (f_watch && ce_s[i] && (d_s[i] == 4'hF)) f_hits++;
    end
  endtask

  // Drive from the falling edge, advance the model at the rising edge, sample 1 time unit later.
  task automatic step(input logic [1:0] v, input logic [W-1:0] dat);
    in_valid_s = v;
    in_data_s  = dat;
    @(posedge clk);
    model_edge(v, dat);
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    pace[0] = 3;
    pace[1] = 1;
    model_reset();

    // reset before any clock edge
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ce",    i, int'(ce_s[i]),       0);
      chk("rst_count", i, int'(count_s[i]),    0);
      chk("rst_ready", i, int'(in_ready_s[i]), 1);
      chk("rst_busy",  i, int'(busy_s[i]),     0);
      chk("rst_d",     i, int'(d_s[i]),        int'(D_RST));
    end
    @(negedge clk);
    rst = 1'b0;
    step(2'b00, 4'h0);

    // single word into an idle sequencer
    step(2'b11, 4'b0110);
    for (int k = 0; k < 6; k++) step(2'b00, 4'h0);

    // held valid, words 1..6 (producer holds word until accepted)
    begin
      logic [W-1:0] w;
      int guard;
      for (int i = 0; i < 2; i++) begin
        w = 4'h1;
        guard = 0;
        while ((w <= 4'h6) && (guard < 60)) begin
          logic acc;
          acc = in_ready_s[i];
          step(i == 0 ? 2'b01 : 2'b10, w);
          if (acc) w = w + 4'h1;
          guard++;
        end
        chk("burst_done", i, (guard < 60) ? 1 : 0, 1);
        for (int k = 0; k < 16; k++) step(2'b00, 4'h0);
      end
    end

    // back-to-back preload 9,A,B,C
    step(2'b11, 4'h9);
    step(2'b11, 4'hA);
    step(2'b11, 4'hB);
    step(2'b11, 4'hC);
    for (int k = 0; k < 14; k++) step(2'b00, 4'h0);

    // async reset mid-burst
    for (int k = 0; k < 5; k++) step(2'b11, 4'(k + 3));
    chk("pre_rst_count", 0, int'(count_s[0]), 3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst_ce",    i, int'(ce_s[i]),    0);
      chk("mid_rst_count", i, int'(count_s[i]), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) step(2'b00, 4'h0);

    // word offered only while full must never be loaded
    begin
      int guard;
      guard = 0;
      while (in_ready_s[0] && (guard < 20)) begin
        step(2'b01, 4'(guard % 6 + 1));
        guard++;
      end
      chk("reached_full", 0, int'(in_ready_s[0]), 0);
      f_watch = 1'b1;
      step(2'b01, 4'hF);
      for (int k = 0; k < 20; k++) step(2'b00, 4'h0);
      f_watch = 1'b0;
      chk("no_F_loaded", 0, f_hits, 0);
    end

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic [1:0] v;
      v[0] = ($urandom_range(0, 3) != 0);
      v[1] = ($urandom_range(0, 1) != 0);
      step(v, 4'($urandom_range(0, 15)));
    end
    for (int k = 0; k < 20; k++) step(2'b00, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
